// File: rtl/dpd_loop_delay_meas_if.sv
// rtl/dpd_loop_delay_meas_if.sv - feedback-path bundle for the DPD loop delay meter
//
// Purpose: groups the measurement control, feedback samples, threshold and
// result signals of dpd_loop_delay_meas into one interface.
// Signals:
//   start        single-cycle measurement start pulse (shared with DPD adaptation start)
//   sig_pa_i/q   signed 20-bit amplifier feedback sample, real/imaginary
//   thr          unsigned 21-bit threshold on |i|+|q|
//   busy         measurement running
//   delay_valid  successful measurement result held
//   timeout      failed measurement result held
//   delay_out    measured delay in cycles
// Modports: master drives stimulus and reads results, slave is the meter.
interface dpd_loop_delay_meas_if #(
  parameter int CW = 16
) ();
  logic                 start;
  logic signed [19:0]   sig_pa_i;
  logic signed [19:0]   sig_pa_q;
  logic        [20:0]   thr;
  logic                 busy;
  logic                 delay_valid;
  logic                 timeout;
  logic        [CW-1:0] delay_out;

  modport master (
    output start, sig_pa_i, sig_pa_q, thr,
    input  busy, delay_valid, timeout, delay_out
  );

  modport slave (
    input  start, sig_pa_i, sig_pa_q, thr,
    output busy, delay_valid, timeout, delay_out
  );
endinterface

// File: rtl/dpd_loop_delay_meas.sv
// rtl/dpd_loop_delay_meas.sv - transmit-to-feedback loop delay measurement for DPD
//
// Purpose: after a start pulse at edge t0, evaluates the feedback sample at
// each edge t0+d (d >= 1) against an L1-magnitude threshold and reports the
// offset d of the first sample of the first run of CONFIRM consecutive
// above-threshold samples. If the sample at offset MAX_DELAY is evaluated
// without such a run completing, the measurement ends in timeout.
// Ports:
//   clk      clock
//   reset_b  asynchronous active-low reset
//   fb       dpd_loop_delay_meas_if.slave (start, samples, thr in; busy,
//            delay_valid, timeout, delay_out out)
module dpd_loop_delay_meas #(
  parameter int MAX_DELAY = 255,
  parameter int CONFIRM   = 4,
  parameter int CW        = 16
) (
  input  logic                  clk,
  input  logic                  reset_b,
  dpd_loop_delay_meas_if.slave  fb
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0]    CONF_N  = 4'(CONFIRM);
  localparam logic [CW-1:0] OFF_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] OFF_SAT = '1;

  // |x| with the most negative code clamped so the magnitude never wraps.
  function automatic logic [19:0] abs_sat(input logic signed [19:0] x);
    logic [19:0] r;
    if (x == 20'sh80000) begin
      r = 20'h7FFFF;
    end else if (x[19]) begin
      r = ~x + 20'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] off_q,   off_d;     // offset of the sample evaluated at the next edge
  logic [3:0]    run_q,   run_d;     // length of the current above-threshold run
  logic [CW-1:0] first_q, first_d;   // offset of the first sample of that run
  logic          busy_q,  busy_d;
  logic          valid_q, valid_d;
  logic          tout_q,  tout_d;
  logic [CW-1:0] delay_q, delay_d;

  logic [20:0] mag;
  logic        hit;
  logic [3:0]  run_inc;
  logic        at_limit;

  assign mag     = {1'b0, abs_sat(fb.sig_pa_i)} + {1'b0, abs_sat(fb.sig_pa_q)};
  assign hit     = (mag > fb.thr);
  assign run_inc = run_q + 4'd1;
  // Widened compare: with a saturated offset counter and MAX_DELAY beyond
  // its range the limit is simply never reached.
  assign at_limit = (32'(off_q) >= 32'(MAX_DELAY));

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    run_d   = run_q;
    first_d = first_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    tout_d  = tout_q;
    delay_d = delay_q;

    // start wins in every state, which also covers restart while running.
    if (fb.start) begin
      state_d = S_RUN;
      off_d   = OFF_ONE;
      run_d   = 4'd0;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      tout_d  = 1'b0;
    end else if (state_q == S_RUN) begin
      off_d = (off_q == OFF_SAT) ? off_q : off_q + OFF_ONE;

      if (hit) begin
        run_d = run_inc;
        if (run_q == 4'd0) begin
          first_d = off_q;
        end
      end else begin
        run_d = 4'd0;
      end

      // The confirming sample is checked before the limit so that a run
      // completing exactly at MAX_DELAY still counts as a success.
      if (hit && (run_inc == CONF_N)) begin
        delay_d = (run_q == 4'd0) ? off_q : first_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end else if (at_limit) begin
        tout_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      run_q   <= 4'd0;
      first_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      run_q   <= run_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
      delay_q <= delay_d;
    end
  end

  assign fb.busy        = busy_q;
  assign fb.delay_valid = valid_q;
  assign fb.timeout     = tout_q;
  assign fb.delay_out   = delay_q;

endmodule

// File: tb/tb_dpd_loop_delay_meas.sv
// tb/tb_dpd_loop_delay_meas.sv - self-checking bench for dpd_loop_delay_meas
module tb_dpd_loop_delay_meas;

  localparam int MAXD = 255;
  localparam int CONF = 4;
  localparam int CW   = 16;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  dpd_loop_delay_meas_if #(.CW(CW)) fb ();

  dpd_loop_delay_meas #(
    .MAX_DELAY(MAXD),
    .CONFIRM  (CONF),
    .CW       (CW)
  ) dut (
    .clk    (clk),
    .reset_b(reset_b),
    .fb     (fb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int smp_i [0:511];
  int smp_q [0:511];
  int prev_delay = 0;

  typedef struct {
    int bg0_i, bg0_q, bg1_i, bg1_q;   // background on even / odd offsets
    int burst, b_i, b_q;              // burst from offset 'burst' on (0 = none)
    int sp_lo, sp_hi, sp_amp;         // spike on i over [sp_lo, sp_hi] (0 = none)
    int thr;
    bit ev;
    int ed;
    bit et;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mag_of(input int i, input int q);
    int ai, aq;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
    if (ai > 524287) ai = 524287;
    if (aq > 524287) aq = 524287;
    return ai + aq;
  endfunction

  // Earliest window of CONF above-threshold samples lying within 1..MAXD.
  function automatic int model_delay(input int thr);
    for (int d = 1; d + CONF - 1 <= MAXD; d++) begin
      bit ok = 1'b1;
      for (int k = 0; k < CONF; k++)
        if (mag_of(smp_i[d+k], smp_q[d+k]) <= thr) ok = 1'b0;
      if (ok) return d;
    end
    return 0;
  endfunction

  task automatic fill(input vec_t v);
    for (int d = 0; d < 512; d++) begin
      smp_i[d] = (d % 2 == 0) ? v.bg0_i : v.bg1_i;
      smp_q[d] = (d % 2 == 0) ? v.bg0_q : v.bg1_q;
      if (v.sp_lo > 0 && d >= v.sp_lo && d <= v.sp_hi) begin
        smp_i[d] = v.sp_amp;
        smp_q[d] = 0;
      end
      if (v.burst > 0 && d >= v.burst) begin
        smp_i[d] = v.b_i;
        smp_q[d] = v.b_q;
      end
    end
  endtask

  task automatic drive(input int d);
    fb.sig_pa_i = 20'(smp_i[d]);
    fb.sig_pa_q = 20'(smp_q[d]);
  endtask

  // Entered and left at a negedge; the start edge is the following posedge.
  task automatic pulse_start();
    fb.start    = 1'b1;
    fb.sig_pa_i = '0;
    fb.sig_pa_q = '0;
    @(posedge clk);
    @(negedge clk);
    fb.start = 1'b0;
  endtask

  // Presents sample d before edge t0+d; returns the d whose edge dropped busy.
  task automatic run_loop(input int nmax, output int end_d);
    end_d = -1;
    for (int d = 1; d <= nmax; d++) begin
      drive(d);
      @(posedge clk);
      @(negedge clk);
      if (!fb.busy) begin
        end_d = d;
        break;
      end
    end
  endtask

  task automatic measure_check(input string name, input int thr,
                               input bit ev, input int ed, input bit et);
    int e, exp_end;
    fb.thr = 21'(thr);
    pulse_start();
    chk({name, " start busy"}, fb.busy, 1);
    chk({name, " start valid"}, fb.delay_valid, 0);
    run_loop(MAXD + 8, e);
    chk({name, " finished"}, (e >= 0), 1);
    chk({name, " valid"}, fb.delay_valid, ev);
    chk({name, " timeout"}, fb.timeout, et);
    chk({name, " delay_out"}, fb.delay_out, ed);
    exp_end = et ? MAXD : ed + CONF - 1;
    if (!(e >= exp_end && e <= exp_end + 3))
      $display("latency %s: ended at %0d, window %0d..%0d", name, e, exp_end, exp_end + 3);
    chk({name, " latency ok"}, (e >= exp_end && e <= exp_end + 3), 1);
  endtask

  vec_t vecs [7];

  initial begin
    int e;
    vec_t v;

    vecs[0] = '{0, 0, 0, 0, 41, 200000, -50000, 0, 0, 0, 10000, 1'b1, 41, 1'b0};
    vecs[1] = '{0, 0, 0, 0, 41, 200000, -50000, 10, 12, 300000, 10000, 1'b1, 41, 1'b0};
    vecs[2] = '{9999, 0, 5000, 5000, 0, 0, 0, 0, 0, 0, 10000, 1'b0, 41, 1'b1};
    vecs[3] = '{0, 0, 0, 0, 5, -524288, -524288, 0, 0, 0, 1048573, 1'b1, 5, 1'b0};
    vecs[4] = '{0, 0, 0, 0, 252, 100000, 0, 0, 0, 0, 50000, 1'b1, 252, 1'b0};
    vecs[5] = '{0, 0, 0, 0, 253, 100000, 0, 0, 0, 0, 50000, 1'b0, 252, 1'b1};
    vecs[6] = '{0, 0, 0, 0, 150, 0, 90000, 100, 102, -90000, 50000, 1'b1, 150, 1'b0};

    fb.start    = 1'b0;
    fb.sig_pa_i = '0;
    fb.sig_pa_q = '0;
    fb.thr      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", fb.busy, 0);
    chk("reset valid", fb.delay_valid, 0);
    chk("reset timeout", fb.timeout, 0);
    chk("reset delay_out", fb.delay_out, 0);
    reset_b = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 7; n++) begin
      fill(vecs[n]);
      measure_check($sformatf("vec%0d", n), vecs[n].thr, vecs[n].ev, vecs[n].ed, vecs[n].et);
    end

    // Restart while running: the first start sees no burst before offset 15.
    v = vecs[0];
    v.burst = 20;
    fill(v);
    fb.thr = 21'd10000;
    pulse_start();
    run_loop(14, e);
    chk("restart first still busy", e, -1);
    chk("restart no early valid", fb.delay_valid, 0);
    v.burst = 60;
    fill(v);
    pulse_start();
    run_loop(MAXD + 8, e);
    chk("restart valid", fb.delay_valid, 1);
    chk("restart delay_out", fb.delay_out, 60);
    chk("restart end offset", (e >= 63 && e <= 66), 1);

    // Reset mid-measurement.
    v.burst = 41;
    fill(v);
    pulse_start();
    run_loop(29, e);
    chk("reset-mid busy before", e, -1);
    reset_b = 1'b0;
    #1;
    chk("reset-mid busy", fb.busy, 0);
    chk("reset-mid delay_out", fb.delay_out, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    chk("reset-mid valid", fb.delay_valid, 0);
    chk("reset-mid timeout", fb.timeout, 0);
    @(negedge clk);
    measure_check("after reset", 10000, 1'b1, 41, 1'b0);
    prev_delay = 41;

    // Randomized feedback checked against the window model.
    for (int r = 0; r < 10; r++) begin
      int thr, p, md;
      thr = int'($urandom_range(1000, 900000));
      p   = int'($urandom_range(5, 60));
      for (int d = 0; d < 512; d++) begin
        if (int'($urandom_range(0, 99)) < p) begin
          smp_i[d] = int'($urandom_range(0, 1048575)) - 524288;
          smp_q[d] = int'($urandom_range(0, 1048575)) - 524288;
        end else begin
          smp_i[d] = int'($urandom_range(0, 1000)) - 500;
          smp_q[d] = int'($urandom_range(0, 1000)) - 500;
        end
      end
      md = model_delay(thr);
      if (md > 0) begin
        measure_check($sformatf("rand%0d", r), thr, 1'b1, md, 1'b0);
        prev_delay = md;
      end else begin
        measure_check($sformatf("rand%0d", r), thr, 1'b0, prev_delay, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dpd_loop_delay_meas.md
Name: dpd_loop_delay_meas

Overview:
Measures the transmit-to-feedback loop delay (transceiver + amplifier) in clock cycles, for use as the DPD delay-compensation value. It watches the amplifier feedback samples after the DPD adaptation start pulse. It reports the cycle offset at which the training burst energy first appears at the feedback input. It sits on the feedback path beside the DPD core and shares its clock and the adaptation start pulse.

Parameters:
MAX_DELAY, 255, largest measurable delay in cycles; a measurement without detection by this offset ends in timeout.
CONFIRM, 4, number of consecutive above-threshold samples needed to accept a detection (rejects noise spikes); range 1..15.
CW, 16, width of the delay counter and of delay_out.

Ports:
clk  in  1  clock
reset_b  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a measurement (same pulse that starts DPD adaptation)
sig_pa_i  in  20  signed feedback from amplifier, real part
sig_pa_q  in  20  signed feedback from amplifier, imaginary part
thr  in  21  unsigned detection threshold on the L1 magnitude; static during a measurement
busy  out  1  high while a measurement is running
delay_valid  out  1  high after a successful measurement, until the next start or reset
timeout  out  1  high after a failed measurement, until the next start or reset
delay_out  out  CW  measured delay in cycles; valid when delay_valid=1

Behaviour:
- Reset values: busy=0, delay_valid=0, timeout=0, delay_out=0; state IDLE; counters=0. Reset mid-measurement aborts it with no result.
- Magnitude: mag = |i| + |q|, unsigned, 21 bits.
  - |x| of -524288 saturates to 524287, so no wrap occurs.
  - Detection condition is mag > thr, a strict compare.
- Offset definition: start is sampled high at edge t0. The feedback sample presented at edge t0+d has offset d, with d ≥ 1. The sample at t0 itself is ignored.
- States:
  - IDLE: waiting for start.
  - RUN: measuring.
  - DONE: result held; behaves as IDLE for start.
- IDLE/DONE + start → RUN at the next cycle. On that transition: busy=1, delay_valid=0, timeout=0, run counter cleared, offset counter=1 for the sample at t0+1. delay_out keeps its old value.
- RUN, each cycle:
  - If the detection condition holds, run counter +1; otherwise run counter clears.
  - The first sample of the current above-threshold run is remembered.
- Success: the run counter reaches CONFIRM.
  - delay_out = offset d of the first sample of that run; delay_valid=1; busy=0; state DONE.
  - Outputs update no later than 3 cycles after the CONFIRM-th qualifying sample. Internal pipelining is allowed, but the reported d must be exact, compensated for pipeline depth.
- Timeout: the sample at offset MAX_DELAY is evaluated without success.
  - timeout=1, busy=0, delay_valid=0, delay_out unchanged; state DONE.
  - A run that started at or before MAX_DELAY but needs samples beyond MAX_DELAY to confirm is a timeout.
- start while RUN: restart. The counters clear and t0 becomes the new start edge; no result is produced for the aborted measurement.
- Success and timeout are never both high. delay_valid and timeout are levels, not pulses.
- Offset counter saturates at all-ones and never wraps, even if MAX_DELAY ≥ 2^CW-1.

Test Plan:
1. thr=10000, CONFIRM=4. Feedback is 0 except i=200000, q=-50000 from offset 41 onward → delay_valid=1, delay_out=41, timeout=0, busy low within 3 cycles after offset 44.
2. Same as 1, plus a 3-sample spike of amplitude 300000 at offsets 10–12 → spike rejected; delay_out=41.
3. Feedback stays below thr (mag=9999, and mag=10000 exactly) through offset 255 → timeout=1, delay_valid=0, delay_out equals the previous result (41).
4. Start; burst appears at offset 20. Restart start pulse issued at offset 15; burst at offset 60 relative to the second start → delay_out=60 relative to the second start; no result from the first start.
5. Feedback i=-524288, q=-524288 from offset 5, thr=1048573 → mag=1048574 > thr; delay_out=5.
6. Start, then reset_b low at offset 30 for 2 cycles → all outputs 0, state IDLE; the next start measures normally (offset 41 → 41).
